// File: rtl/elastic_join_pkg.sv
// Shared widths, types and channel-select helper for the PE operand-gathering stage.
package elastic_join_pkg;

   localparam int unsigned DATA_WIDTH      = 32;
   localparam int unsigned NEIGHBOR_PE_NUM = 4;
   localparam int unsigned SEL_WIDTH       = $clog2(NEIGHBOR_PE_NUM);
   localparam int unsigned CNT_WIDTH       = 2;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [SEL_WIDTH-1:0]  sel_t;
   typedef logic [CNT_WIDTH-1:0]  cnt_t;

   localparam cnt_t CNT_ONE  = CNT_WIDTH'(1);
   localparam cnt_t CNT_FULL = CNT_WIDTH'(2);

   // True when an enabled operand selects channel ch.
   function automatic logic chan_hit(input logic en, input sel_t sel, input int unsigned ch);
      return en && (sel == SEL_WIDTH'(ch));
   endfunction

endpackage

// File: rtl/elastic_buffer.sv
// Two-entry elastic buffer: main register is the head, aux holds the second token.
module elastic_buffer
   import elastic_join_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  data_t in_data,
   input  logic  in_valid,
   output logic  in_stop,
   output data_t out_data,
   output logic  out_valid,
   input  logic  pop
);

   cnt_t  count;
   data_t main_q;
   data_t aux_q;
   logic  push;
   logic  pop_ok;

   // Stop depends only on the registered fill level.
   assign in_stop   = (count == CNT_FULL);
   assign push      = in_valid && !in_stop;
   assign pop_ok    = pop && (count != '0);
   assign out_data  = main_q;
   assign out_valid = (count != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count  <= '0;
         main_q <= '0;
         aux_q  <= '0;
      end else begin
         unique case ({push, pop_ok})
            2'b10: begin
               if (count == '0) main_q <= in_data;
               else             aux_q  <= in_data;
               count <= count + CNT_ONE;
            end
            2'b01: begin
               if (count == CNT_FULL) main_q <= aux_q;
               count <= count - CNT_ONE;
            end
            2'b11: begin
               // Push is blocked when full, so this only happens with one token held.
               main_q <= in_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/elastic_join.sv
// Buffers every neighbour channel, selects up to two operands and joins them into one pair.
module elastic_join
   import elastic_join_pkg::*;
(
   input  logic                                       clk,
   input  logic                                       reset_n,
   input  logic [NEIGHBOR_PE_NUM-1:0][DATA_WIDTH-1:0] input_data,
   input  logic [NEIGHBOR_PE_NUM-1:0]                 valid_input,
   output logic [NEIGHBOR_PE_NUM-1:0]                 stop_input,
   input  logic                                       enable_a,
   input  sel_t                                       sel_a,
   input  logic                                       enable_b,
   input  sel_t                                       sel_b,
   output data_t                                      output_data_a,
   output data_t                                      output_data_b,
   output logic                                       valid_output,
   input  logic                                       stop_output,
   output logic                                       idle
);

   logic [NEIGHBOR_PE_NUM-1:0] selected;
   logic [NEIGHBOR_PE_NUM-1:0] full;
   logic [NEIGHBOR_PE_NUM-1:0] ch_valid;
   logic [NEIGHBOR_PE_NUM-1:0] pop;
   data_t                      head [NEIGHBOR_PE_NUM];
   logic                       fire;

   // Select decode from the current context.
   always_comb begin
      selected = '0;
      for (int unsigned i = 0; i < NEIGHBOR_PE_NUM; i++) begin
         selected[i] = chan_hit(enable_a, sel_a, i) || chan_hit(enable_b, sel_b, i);
      end
   end

   for (genvar g = 0; g < NEIGHBOR_PE_NUM; g++) begin : g_ch
      elastic_buffer u_buf (
         .clk       (clk),
         .reset_n   (reset_n),
         .in_data   (input_data[g]),
         .in_valid  (valid_input[g] & selected[g]),
         .in_stop   (full[g]),
         .out_data  (head[g]),
         .out_valid (ch_valid[g]),
         .pop       (pop[g])
      );
   end

   // Unselected channels are held off; no path from stop_output reaches here.
   assign stop_input = ~selected | full;

   assign valid_output = (enable_a || enable_b)
                      && (!enable_a || ch_valid[sel_a])
                      && (!enable_b || ch_valid[sel_b]);

   // A channel selected by both operands still pops only once.
   assign fire = valid_output && !stop_output;
   assign pop  = {NEIGHBOR_PE_NUM{fire}} & selected;

   assign output_data_a = enable_a ? head[sel_a] : '0;
   assign output_data_b = enable_b ? head[sel_b] : '0;
   assign idle          = ~|ch_valid;

endmodule
